seq_alu_mc: RTL and testbench

- Parametrised, clocked successor to the 4-bit combinational ALU.
- Latches operands and opcode on a start/done handshake.
- Single-cycle ops: add, sub, logic, shifts.
- Multi-cycle ops: shift-add multiply and restoring divide/modulo.
- Holds result and flags in registers until the next operation completes, so display converters and the top-level opcode decoder read stable values.

---
 rtl/seq_alu_mc.sv | 213 +++++++++++++++++++++
 tb/tb_seq_alu_mc.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu_mc.sv
// rtl/seq_alu_mc.sv - clocked ALU with start/done handshake, shift-add multiply and restoring divide
// Single-cycle ops complete straight into DONE; mul/div iterate N times over {acc_hi, acc_lo}.
module seq_alu_mc #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic [N-1:0] result_hi,
  output logic         carry,
  output logic         zero,
  output logic         negative,
  output logic         overflow,
  output logic         err
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    op_q;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [N-1:0]  acc_hi;
  logic [N-1:0]  acc_lo;

  logic [SW-1:0] k;
  logic          shamt_ok;
  logic [N:0]    add_w;
  logic [N:0]    sub_w;
  logic [N:0]    shl_w;
  logic [N:0]    shr_w;
  logic [N-1:0]  sc_res;
  logic          sc_c;
  logic          sc_v;
  logic          sc_err;

  logic [N:0]    msum;
  logic [2*N-1:0] mcat;
  logic [N:0]    dshift;
  logic [N:0]    dsub;
  logic [N-1:0]  rem_n;
  logic [N-1:0]  quo_n;

  assign busy = (state != S_IDLE);

  // Single-cycle results are computed from the live inputs at the sampling edge.
  always_comb begin
    k        = B[SW-1:0];
    shamt_ok = ((B >> SW) == '0) && (int'(k) < N);
    add_w    = {1'b0, A} + {1'b0, B};
    sub_w    = {1'b0, A} - {1'b0, B};
    shl_w    = {1'b0, A} << k;
    shr_w    = {A, 1'b0} >> k;
    sc_res   = '0;
    sc_c     = 1'b0;
    sc_v     = 1'b0;
    sc_err   = 1'b0;
    case (op)
      4'd0: begin
        sc_res = add_w[N-1:0];
        sc_c   = add_w[N];
        sc_v   = (A[N-1] == B[N-1]) && (add_w[N-1] != A[N-1]);
      end
      4'd1: begin
        sc_res = sub_w[N-1:0];
        sc_c   = sub_w[N];
        sc_v   = (A[N-1] != B[N-1]) && (sub_w[N-1] != A[N-1]);
      end
      4'd2: sc_res = '0;
      4'd3: begin
        sc_res = '1;
        sc_err = 1'b1;
      end
      4'd4: begin
        sc_res = A;
        sc_err = 1'b1;
      end
      4'd5: sc_res = A & B;
      4'd6: sc_res = A | B;
      4'd7: sc_res = A ^ B;
      4'd8: begin
        if (shamt_ok) begin
          sc_res = shl_w[N-1:0];
          sc_c   = shl_w[N];
        end
      end
      4'd9: begin
        if (shamt_ok) begin
          sc_res = shr_w[N:1];
          sc_c   = shr_w[0];
        end
      end
      default: sc_err = 1'b1;
    endcase
  end

  // One iteration of each multi-cycle algorithm; the FSM applies it once per clock.
  always_comb begin
    msum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_q} : '0);
    mcat   = {msum, acc_lo[N-1:1]};
    dshift = {acc_hi, acc_lo[N-1]};
    dsub   = dshift - {1'b0, b_q};
    if (!dsub[N]) begin
      rem_n = dsub[N-1:0];
      quo_n = {acc_lo[N-2:0], 1'b1};
    end else begin
      rem_n = dshift[N-1:0];
      quo_n = {acc_lo[N-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      done      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      overflow  <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (state == S_DONE) state <= S_IDLE;
          if (start) begin
            op_q <= op;
            a_q  <= A;
            b_q  <= B;
            if (op == 4'd2 && B != '0) begin
              state  <= S_MUL;
              acc_hi <= '0;
              acc_lo <= B;
              cnt    <= CW'(N - 1);
            end else if ((op == 4'd3 || op == 4'd4) && B != '0) begin
              state  <= S_DIV;
              acc_hi <= '0;
              acc_lo <= A;
              cnt    <= CW'(N - 1);
            end else begin
              state     <= S_DONE;
              done      <= 1'b1;
              result    <= sc_res;
              result_hi <= '0;
              carry     <= sc_c;
              zero      <= (sc_res == '0);
              negative  <= sc_res[N-1];
              overflow  <= sc_v;
              err       <= sc_err;
            end
          end
        end
        S_MUL: begin
          acc_hi <= mcat[2*N-1:N];
          acc_lo <= mcat[N-1:0];
          cnt    <= cnt - CW'(1);
          if (cnt == '0) begin
            state     <= S_DONE;
            done      <= 1'b1;
            result    <= mcat[N-1:0];
            result_hi <= mcat[2*N-1:N];
            carry     <= 1'b0;
            zero      <= (mcat == '0);
            negative  <= mcat[N-1];
            overflow  <= (mcat[2*N-1:N] != '0);
            err       <= 1'b0;
          end
        end
        S_DIV: begin
          acc_hi <= rem_n;
          acc_lo <= quo_n;
          cnt    <= cnt - CW'(1);
          if (cnt == '0) begin
            state     <= S_DONE;
            done      <= 1'b1;
            result    <= (op_q == 4'd3) ? quo_n : rem_n;
            result_hi <= '0;
            carry     <= 1'b0;
            zero      <= (((op_q == 4'd3) ? quo_n : rem_n) == '0);
            negative  <= (op_q == 4'd3) ? quo_n[N-1] : rem_n[N-1];
            overflow  <= 1'b0;
            err       <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu_mc.sv
// tb/tb_seq_alu_mc.sv - scoreboard bench for seq_alu_mc against an arithmetic reference model
// Stimulus pushes expectations; a negedge monitor pops and compares on every done.
module tb_seq_alu_mc;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   op = '0;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic [N-1:0] result_hi;
  logic         carry;
  logic         zero;
  logic         negative;
  logic         overflow;
  logic         err;

  seq_alu_mc #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .result(result), .result_hi(result_hi),
    .carry(carry), .zero(zero), .negative(negative), .overflow(overflow), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] res;
    logic [N-1:0] hi;
    logic [4:0]   fl;
    int           lat;
    int           done_cyc;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           passes = 0;
  logic [N-1:0] last_res = '0;
  logic         prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
  endtask

  // Reference model: plain integer arithmetic with signed range checks.
  function automatic exp_t model(input int o, input int a, input int b);
    exp_t e;
    int m, sa, sbv, s, k, r, hi, c, v, er;
    m = 1 << N;
    r = 0; hi = 0; c = 0; v = 0; er = 0;
    e.lat = 0;
    e.done_cyc = 0;
    sa  = (a >= m / 2) ? a - m : a;
    sbv = (b >= m / 2) ? b - m : b;
    case (o)
      0: begin
        s = a + b; r = s % m; c = int'(s >= m);
        v = int'((sa + sbv > m / 2 - 1) || (sa + sbv < -m / 2));
      end
      1: begin
        r = (a - b + m) % m; c = int'(a < b);
        v = int'((sa - sbv > m / 2 - 1) || (sa - sbv < -m / 2));
      end
      2: begin
        s = a * b; r = s % m; hi = s / m; v = int'(hi != 0);
        e.lat = (b != 0) ? N : 0;
      end
      3: if (b == 0) begin r = m - 1; er = 1; end else begin r = a / b; e.lat = N; end
      4: if (b == 0) begin r = a; er = 1; end else begin r = a % b; e.lat = N; end
      5: r = a & b;
      6: r = a | b;
      7: r = a ^ b;
      8: begin
        k = b % N;
        if (b / N == 0) begin
          r = (a << k) % m;
          c = (k == 0) ? 0 : ((a >> (N - k)) & 1);
        end
      end
      9: begin
        k = b % N;
        if (b / N == 0) begin
          r = a >> k;
          c = (k == 0) ? 0 : ((a >> (k - 1)) & 1);
        end
      end
      default: er = 1;
    endcase
    e.res = r[N-1:0];
    e.hi  = hi[N-1:0];
    e.fl  = {c[0], (r == 0 && hi == 0), r[N-1], v[0], er[0]};
    return e;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        chk("done_pulse_width", 32'(prev_done), 32'(0));
        if (exp_q.size() == 0) begin
          chk("spurious_done", 32'(done), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("result", 32'(result), 32'(e.res));
          chk("result_hi", 32'(result_hi), 32'(e.hi));
          chk("flags_czngv_e", 32'({carry, zero, negative, overflow, err}), 32'(e.fl));
          chk("done_latency_cycle", 32'(cyc), 32'(e.done_cyc));
          last_res = e.res;
        end
      end
      prev_done = done;
    end
  end

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 64) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'(0));
      exp_q.delete();
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [N-1:0] a, input logic [N-1:0] b, input bit poke);
    exp_t e;
    drain();
    e = model(int'(o), int'(a), int'(b));
    e.done_cyc = cyc + 1 + e.lat;
    exp_q.push_back(e);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 4'($urandom); A = N'($urandom); B = N'($urandom);
    if (e.lat > 0) begin
      chk("busy_multicycle", 32'(busy), 32'(1));
      chk("result_hold", 32'(result), 32'(last_res));
      if (poke) begin
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; op = 4'd0; A = N'($urandom); B = N'($urandom);
        @(negedge clk);
        start = 1'b0;
      end
    end
  endtask

  typedef struct {
    logic [3:0]   o;
    logic [N-1:0] a;
    logic [N-1:0] b;
    bit           poke;
  } vec_t;

  vec_t dir[$];

  initial begin : stim
    logic [3:0]   ro;
    logic [N-1:0] ra, rb;
    dir = '{
      '{4'd0, 8'h7F, 8'h01, 1'b0}, '{4'd0, 8'hFF, 8'h01, 1'b0},
      '{4'd1, 8'h03, 8'h05, 1'b0}, '{4'd1, 8'h80, 8'h01, 1'b0},
      '{4'd2, 8'hFF, 8'hFF, 1'b1}, '{4'd3, 8'd200, 8'd7, 1'b0},
      '{4'd4, 8'd200, 8'd7, 1'b1}, '{4'd3, 8'd5, 8'd0, 1'b0},
      '{4'd5, 8'hF0, 8'h3C, 1'b0}, '{4'd8, 8'h81, 8'h01, 1'b0},
      '{4'd9, 8'h81, 8'h00, 1'b0}, '{4'd9, 8'h81, 8'h08, 1'b0},
      '{4'hC, 8'h55, 8'h11, 1'b0}, '{4'd2, 8'h00, 8'h37, 1'b0},
      '{4'd0, 8'h7F, 8'h01, 1'b0}
    };

    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    chk("reset_result", 32'(result), 32'(0));
    chk("reset_result_hi", 32'(result_hi), 32'(0));
    chk("reset_flags", 32'({carry, zero, negative, overflow, err}), 32'(0));
    reset = 1'b0;
    @(negedge clk);

    foreach (dir[i]) issue(dir[i].o, dir[i].a, dir[i].b, dir[i].poke);

    // Abort a multiply after its third iteration.
    drain();
    start = 1'b1; op = 4'd2; A = 8'h12; B = 8'h34;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_result", 32'(result), 32'(0));
    chk("abort_result_hi", 32'(result_hi), 32'(0));
    chk("abort_flags", 32'({carry, zero, negative, overflow, err}), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    last_res = '0;
    repeat (12) @(negedge clk);
    chk("abort_idle_busy", 32'(busy), 32'(0));
    issue(4'd6, 8'hA0, 8'h05, 1'b0);

    for (int i = 0; i < 250; i++) begin
      ro = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) ro = 4'($urandom_range(2, 4));
      ra = N'($urandom);
      rb = N'($urandom);
      if ((ro == 4'd3 || ro == 4'd4) && $urandom_range(0, 7) == 0) rb = '0;
      if ((ro == 4'd8 || ro == 4'd9) && $urandom_range(0, 3) != 0) rb = N'($urandom_range(0, 9));
      issue(ro, ra, rb, bit'($urandom_range(0, 1)));
    end

    drain();
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
